output_condition: RTL and testbench
===================================

OUTPUT_CONDITION -- requirements
Module: output_condition

Interface
REQ-001 SHALL have parameter HOLD, default 8: number of cycles `level` is held high per accepted request; legal range 1..255.
REQ-002 SHALL have parameter GAP, default 2: minimum number of low cycles after a hold, during which requests are not accepted; legal range 0..255.
REQ-003 SHALL have parameter RETRIG, default 0: 1 means a request during HOLD restarts the hold; 0 means it is dropped.
REQ-004 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port Resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port pulse, input, 1 bit: request strobe; every cycle sampled high counts as one request.
REQ-007 SHALL have port level, output, 1 bit: stretched output level, driven directly from a register.
REQ-008 SHALL have port busy, output, 1 bit: high whenever the block is not in IDLE, driven from a register.
REQ-009 SHALL have port dropped, output, 1 bit: single-cycle flag marking an ignored request, driven from a register.

Function
REQ-010 SHALL implement a 3-state FSM (IDLE, HOLD, GAP) with a down-counter cnt sized to hold max(HOLD,GAP)-1.
REQ-011 SHALL, in IDLE with pulse=1, enter HOLD on the next edge with cnt=HOLD-1, so `level` rises exactly 1 cycle after the request cycle.
REQ-012 SHALL drive level=1 iff state==HOLD and busy=1 iff state!=IDLE.
REQ-013 SHALL, in HOLD, decrement cnt each cycle so that `level` stays high for exactly HOLD consecutive cycles when no retrigger occurs.
REQ-014 SHALL, in HOLD with cnt==0 and no accepted retrigger, go to GAP with cnt=GAP-1 if GAP>0, otherwise go directly to IDLE.
REQ-015 SHALL, in GAP, decrement cnt and go to IDLE on the edge after cnt==0, giving exactly GAP low busy cycles.
REQ-016 SHALL, with RETRIG=1 and pulse=1 in any HOLD cycle (including the cnt==0 cycle), reload cnt=HOLD-1 and stay in HOLD, keeping `level` high without a glitch.
REQ-017 SHALL, with RETRIG=0 and pulse=1 in HOLD, ignore the request and assert `dropped` for the one following cycle.
REQ-018 SHALL, with pulse=1 in any GAP cycle (including the last one), ignore the request and assert `dropped` for the one following cycle.
REQ-019 SHALL accept requests only in IDLE or on retrigger, and SHALL never buffer or queue them.
REQ-020 SHALL treat a multi-cycle-high pulse as one request per cycle, each handled by REQ-011 and REQ-016 to REQ-018.
REQ-021 SHALL hold dropped=0 in every cycle that is not covered by REQ-017 or REQ-018.

Reset
REQ-022 SHALL, while Resetn=0, immediately force state=IDLE, cnt=0, level=0, busy=0 and dropped=0, regardless of the clock.
REQ-023 SHALL, on Resetn deassertion mid-operation, resume from IDLE and ignore any request that was interrupted.
REQ-024 SHALL treat pulse=1 on the first edge after reset release as a normal IDLE request.

Verification
REQ-025 SHALL cover, with HOLD=4, GAP=2, RETRIG=0 and cycle 0 the pulse cycle, these directed scenarios:
- Single pulse at 0 -> level=1 in cycles 1-4; busy=1 in cycles 1-6; IDLE at 7; dropped never asserted.
- Pulses at 0 and 2 -> dropped=1 only in cycle 3; level=1 in cycles 1-4 only.
- Pulse at 6 (GAP) -> dropped=1 at 7; pulse at 7 (IDLE) is accepted -> level=1 in cycles 8-11.
- Resetn low in cycle 2 (mid-HOLD) -> level/busy/dropped go to 0 in that same cycle, asynchronously; a pulse after release -> level=1 for 4 cycles.
REQ-026 SHALL cover, with RETRIG=1, pulses at 0 and 3 -> level=1 continuously in cycles 1-7; busy falls at cycle 10.
REQ-027 SHALL cover, with GAP=0, pulses at 4 and 5 -> dropped=1 at 5, and level=0 at 5 then level=1 in cycles 6-9.

Source files
------------

// File: rtl/output_condition.sv
// output_condition: request pulse stretcher with hold, gap and retrigger.
// All outputs are registered; asynchronous active-low reset.
module output_condition #(
  parameter int HOLD   = 8,
  parameter int GAP    = 2,
  parameter int RETRIG = 0
) (
  input  logic Clock,
  input  logic Resetn,
  input  logic pulse,
  output logic level,
  output logic busy,
  output logic dropped
);

  localparam int MAXC = (HOLD > GAP) ? HOLD : GAP;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'((GAP > 0) ? GAP - 1 : 0);
  localparam bit            HAS_GAP = (GAP > 0);
  localparam bit            RT_EN   = (RETRIG != 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_GAP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q;
  logic          busy_q;
  logic          drop_q, drop_d;
  logic          cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // next state, counter reload/decrement and drop detection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drop_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pulse) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      S_HOLD: begin
        if (pulse && RT_EN) begin
          cnt_d = HOLD_LD;
        end else begin
          drop_d = pulse;
          if (cnt_zero) begin
            if (HAS_GAP) begin
              state_d = S_GAP;
              cnt_d   = GAP_LD;
            end else begin
              state_d = S_IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_GAP: begin
        drop_d = pulse;
        if (cnt_zero) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // state, counter and outputs registered from the next state
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= (state_d == S_HOLD);
      busy_q  <= (state_d != S_IDLE);
      drop_q  <= drop_d;
    end
  end

  assign level   = level_q;
  assign busy    = busy_q;
  assign dropped = drop_q;

endmodule

// File: tb/tb_output_condition.sv
// tb_output_condition: directed + random checks of output_condition
// against a cycle-window reference model, several parameter sets.
module tb_output_condition;

  localparam int NU = 5;
  localparam int HP[NU] = '{4, 4, 4, 1, 3};
  localparam int GP[NU] = '{2, 2, 0, 0, 5};
  localparam int RP[NU] = '{0, 1, 0, 0, 1};

  logic          Clock = 1'b0;
  logic          Resetn;
  logic [NU-1:0] pulse;
  logic [NU-1:0] level;
  logic [NU-1:0] busy;
  logic [NU-1:0] dropped;

  always #5 Clock = ~Clock;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    output_condition #(
      .HOLD  (HP[g]),
      .GAP   (GP[g]),
      .RETRIG(RP[g])
    ) u_dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .pulse  (pulse[g]),
      .level  (level[g]),
      .busy   (busy[g]),
      .dropped(dropped[g])
    );
  end

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int t0     = 0;

  // model: last cycle of level high, last busy cycle, cycle of drop flag
  int hold_until[NU];
  int busy_until[NU];
  int drop_at[NU];

  logic [2:0] hist[NU][32];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NU; i++) begin
      hold_until[i] = -1;
      busy_until[i] = -1;
      drop_at[i]    = -1;
    end
  endtask

  task automatic step(input logic [NU-1:0] p);
    int off;
    @(negedge Clock);
    off = cyc - t0;
    for (int i = 0; i < NU; i++) begin
      chk($sformatf("level%0d@%0d", i, cyc), level[i], cyc <= hold_until[i]);
      chk($sformatf("busy%0d@%0d", i, cyc), busy[i], cyc <= busy_until[i]);
      chk($sformatf("drop%0d@%0d", i, cyc), dropped[i], cyc == drop_at[i]);
      if (off >= 0 && off < 32)
        hist[i][off] = {dropped[i], busy[i], level[i]};
    end
    pulse = p;
    for (int i = 0; i < NU; i++) begin
      if (p[i]) begin
        if (cyc > busy_until[i] || (RP[i] != 0 && cyc <= hold_until[i])) begin
          hold_until[i] = cyc + HP[i];
          busy_until[i] = cyc + HP[i] + GP[i];
        end else begin
          drop_at[i] = cyc + 1;
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step('0);
  endtask

  task automatic scen(input logic [31:0] pm, input int len);
    logic [NU-1:0] p;
    idle(12);
    t0 = cyc;
    for (int o = 0; o < len; o++) begin
      p = pm[o] ? '1 : '0;
      step(p);
    end
    step('0);
  endtask

  task automatic async_reset();
    @(negedge Clock);
    #2 Resetn = 1'b0;
    #1;
    for (int i = 0; i < NU; i++) begin
      chk($sformatf("arst_level%0d", i), level[i], 1'b0);
      chk($sformatf("arst_busy%0d", i), busy[i], 1'b0);
      chk($sformatf("arst_drop%0d", i), dropped[i], 1'b0);
    end
    @(posedge Clock);
    #2 Resetn = 1'b1;
    cyc++;
    model_reset();
  endtask

  initial begin
    logic [NU-1:0] p;
    int dens;
    Resetn = 1'b0;
    pulse  = '0;
    model_reset();
    #1;
    for (int i = 0; i < NU; i++) begin
      chk($sformatf("rst_level%0d", i), level[i], 1'b0);
      chk($sformatf("rst_busy%0d", i), busy[i], 1'b0);
      chk($sformatf("rst_drop%0d", i), dropped[i], 1'b0);
    end
    @(posedge Clock);
    #2 Resetn = 1'b1;

    // single request
    scen(32'h1, 10);
    for (int o = 0; o <= 10; o++) begin
      chk($sformatf("A_level@%0d", o), hist[0][o][0], o >= 1 && o <= 4);
      chk($sformatf("A_busy@%0d", o), hist[0][o][1], o >= 1 && o <= 6);
      chk($sformatf("A_drop@%0d", o), hist[0][o][2], 1'b0);
    end

    // request during hold is dropped
    scen(32'h5, 10);
    for (int o = 0; o <= 10; o++) begin
      chk($sformatf("B_level@%0d", o), hist[0][o][0], o >= 1 && o <= 4);
      chk($sformatf("B_drop@%0d", o), hist[0][o][2], o == 3);
    end

    // request in gap dropped, next in idle accepted
    scen(32'hC1, 14);
    for (int o = 0; o <= 14; o++) begin
      chk($sformatf("C_level@%0d", o), hist[0][o][0],
          (o >= 1 && o <= 4) || (o >= 8 && o <= 11));
      chk($sformatf("C_drop@%0d", o), hist[0][o][2], o == 7);
    end

    // retrigger extends the hold
    scen(32'h9, 12);
    for (int o = 0; o <= 12; o++) begin
      chk($sformatf("D_level@%0d", o), hist[1][o][0], o >= 1 && o <= 7);
      chk($sformatf("D_busy@%0d", o), hist[1][o][1], o >= 1 && o <= 9);
    end

    // no gap: last-hold request dropped, next cycle accepted
    scen(32'h31, 12);
    for (int o = 0; o <= 12; o++) begin
      chk($sformatf("E_level@%0d", o), hist[2][o][0],
          (o >= 1 && o <= 4) || (o >= 6 && o <= 9));
      chk($sformatf("E_drop@%0d", o), hist[2][o][2], o == 5);
    end

    // async reset mid-hold, then request on first edge after release
    idle(12);
    t0 = cyc;
    step('1);
    step('0);
    async_reset();
    t0 = cyc;
    step('1);
    idle(6);
    for (int o = 0; o <= 6; o++)
      chk($sformatf("R_level@%0d", o), hist[0][o][0], o >= 1 && o <= 4);

    // random traffic with varying density and occasional resets
    t0 = -1000;
    dens = 3;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) dens = $urandom_range(1, 9);
      for (int i = 0; i < NU; i++)
        p[i] = ($urandom_range(0, 9) < dens);
      if ($urandom_range(0, 399) == 0) async_reset();
      else step(p);
    end
    idle(12);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
